rv_fwd_unit: RTL and testbench
==============================

RV_FWD_UNIT -- requirements
Module: rv_fwd_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NREG, default 32: register count; AW = clog2(NREG); register 0 reads as zero and is never tracked.
REQ-003 Parameter DEPTH, default 3: number of in-flight tracking stages (S1..SDEPTH), range 2..8.
REQ-004 Parameter LD_STAGE, default 2: stage at which load data arrives, range 2..DEPTH.
REQ-005 Parameter NRD, default 2: number of forwarded read ports, range 1..4.
REQ-006 Port clk  input  1  single clock; all state updates on rising edge.
REQ-007 Port rst  input  1  synchronous, active-high reset.
REQ-008 Port iss_valid/iss_wen/iss_load  input  1 each  an instruction is issuing / writes rd / is a load.
REQ-009 Port iss_rd  input  AW  destination of the issuing instruction.
REQ-010 Port flush  input  1  kill the issuing instruction and the S1 entry.
REQ-011 Port exe_data  input  XLEN  combinational result of the instruction in S1.
REQ-012 Port ld_data  input  XLEN  load data for the load in S[LD_STAGE].
REQ-013 Port rs_addr  input  NRD*AW, and rf_data  input  NRD*XLEN: per-port source index and raw register-file data.
REQ-014 Port fwd_data  output  NRD*XLEN  per-port forwarded operand.
REQ-015 Port stall  output  1  the issue must be held this cycle.
REQ-016 Ports wb_valid 1, wb_rd AW, wb_data XLEN  outputs  retirement write to the register file from SDEPTH.
REQ-017 Port stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-018 Each stage holds v, rd, ld, dv, data; the whole chain shifts by one stage every cycle (no global hold).
REQ-019 S1 loads {v=1, rd, ld=iss_load, dv=0} when iss_valid & iss_wen & iss_rd!=0 & !stall & !flush; otherwise S1 becomes a bubble (v=0).
REQ-020 flush forces S2 to a bubble on the next edge (the S1 entry is killed) and blocks S1 capture; older stages are unaffected.
REQ-021 On shift S1->S2, a non-load captures data=exe_data, dv=1; a load keeps dv=0.
REQ-022 On shift S[LD_STAGE]->S[LD_STAGE+1], a load captures data=ld_data, dv=1; when LD_STAGE=DEPTH, ld_data goes directly to wb_data.
REQ-023 wb_valid=SDEPTH.v, wb_rd=SDEPTH.rd, wb_data=SDEPTH.data (or ld_data per REQ-022), combinational from stage state.
REQ-024 Per port: rs_addr=0 -> fwd_data=0; otherwise the youngest stage (S1 first) with v & rd==rs_addr supplies the value; no match -> rf_data.
REQ-025 Value of the matched stage: S1 non-load -> exe_data; load in S[LD_STAGE] -> ld_data; dv=1 -> stored data; anything else is not ready.
REQ-026 stall=iss_valid & !flush & (any port matches a not-ready stage); a stalled issue is not captured and is re-presented by the core.
REQ-027 An older match is never used when a younger match exists, even if the younger one is not ready.
REQ-028 A port reading the register being written by SDEPTH in the same cycle receives the forwarded value, not rf_data.
REQ-029 stall_cnt increments by 1 every cycle stall=1 and saturates at 16'hFFFF.
REQ-030 fwd_data and stall are purely combinational from stage state and inputs (zero-cycle latency).

Reset
REQ-031 On rst=1 at a clock edge, all stage v, dv and data clear to 0 and stall_cnt clears to 0; a write issued in the same cycle is dropped.
REQ-032 While state is reset: wb_valid=0, wb_rd=0, wb_data=0, stall=0, fwd_data=rf_data (or 0 for rs_addr=0).

Verification (DEPTH=3, LD_STAGE=2, NRD=2)
REQ-033 ALU back-to-back: issue x5 (non-load); next cycle rs_addr0=5, exe_data=0x11 -> fwd_data0=0x11, stall=0.
REQ-034 Load-use: issue load x6; next cycle rs_addr1=6 -> stall=1 for exactly 1 cycle; following cycle ld_data=0xAB -> fwd_data1=0xAB, stall=0, stall_cnt=1.
REQ-035 Youngest wins: x7=0x1 in S3, x7=0x2 in S2, read x7 -> 0x2; rs_addr=0 with a tracked write pending -> 0.
REQ-036 Flush: issue x8 with flush=1 -> S1 empty, read x8 next cycle -> rf_data; flush one cycle after issuing x9 -> x9 never reaches wb_valid.
REQ-037 Retirement: x10=0x55 issued, exe_data=0x55 -> wb_valid=1, wb_rd=10, wb_data=0x55 exactly 3 cycles after issue; same-cycle read of x10 -> 0x55.
REQ-038 Reset mid-flight: three writes in flight, assert rst one cycle -> wb_valid stays 0, stall=0, stall_cnt=0; stall_cnt driven past 0xFFFF holds 0xFFFF.

Source files
------------

// File: rtl/rv_fwd_unit.sv
// rv_fwd_unit
//   Operand forwarding and load-use hazard detection for a short in-order
//   pipeline. A chain of DEPTH tracking stages (S1..SDEPTH) follows each
//   register-writing instruction from issue to retirement. Read ports pick
//   the youngest in-flight producer of their source register, or fall back
//   to the register file. When that producer's value is not available yet,
//   the issue is stalled.
//
// Ports
//   clk_i, rst_i        clock and synchronous active-high reset
//   iss_valid_i         an instruction is issuing this cycle
//   iss_wen_i           the issuing instruction writes iss_rd_i
//   iss_load_i          the issuing instruction is a load
//   iss_rd_i            destination register of the issuing instruction
//   flush_i             kill the issuing instruction and the S1 entry
//   exe_data_i          combinational result of the instruction in S1
//   ld_data_i           load data for the load sitting in S[LD_STAGE]
//   rs_addr_i           NRD packed source register indices
//   rf_data_i           NRD packed raw register-file read values
//   fwd_data_o          NRD packed forwarded operands
//   stall_o             the issue must be held this cycle
//   wb_valid_o/rd/data  retirement write from SDEPTH
//   stall_cnt_o         saturating count of stalled cycles

module rv_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int LD_STAGE = 2,
  parameter int NRD      = 2,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                iss_valid_i,
  input  logic                iss_wen_i,
  input  logic                iss_load_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     exe_data_i,
  input  logic [XLEN-1:0]     ld_data_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  input  logic [NRD*XLEN-1:0] rf_data_i,
  output logic [NRD*XLEN-1:0] fwd_data_o,
  output logic                stall_o,
  output logic                wb_valid_o,
  output logic [AW-1:0]       wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [15:0]         stall_cnt_o
);

  // Index k holds stage S(k+1).
  logic            v_q    [DEPTH];
  logic            v_d    [DEPTH];
  logic [AW-1:0]   rd_q   [DEPTH];
  logic [AW-1:0]   rd_d   [DEPTH];
  logic            ld_q   [DEPTH];
  logic            ld_d   [DEPTH];
  logic            dv_q   [DEPTH];
  logic            dv_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic [XLEN-1:0] sval [DEPTH];
  logic            srdy [DEPTH];

  logic [NRD-1:0]  port_wait;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] sel;
  logic            pw;
  logic            stall;
  logic            capture;
  logic [15:0]     stall_cnt_q;
  logic [15:0]     stall_cnt_d;

  // Value each stage can offer this cycle. A non-load in S1 is ready from
  // the execute result; a load becomes ready in S[LD_STAGE] from ld_data.
  always_comb begin : stage_value
    for (int k = 0; k < DEPTH; k++) begin
      sval[k] = data_q[k];
      srdy[k] = dv_q[k];
      if (k == 0 && !ld_q[k]) begin
        sval[k] = exe_data_i;
        srdy[k] = 1'b1;
      end
      if (k == LD_STAGE - 1 && ld_q[k]) begin
        sval[k] = ld_data_i;
        srdy[k] = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones,
  // including when the youngest is not ready yet.
  always_comb begin : forward
    fwd_data_o = '0;
    port_wait  = '0;
    addr       = '0;
    sel        = '0;
    pw         = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      addr = rs_addr_i[p*AW +: AW];
      sel  = rf_data_i[p*XLEN +: XLEN];
      pw   = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && rd_q[k] == addr) begin
          sel = sval[k];
          pw  = ~srdy[k];
        end
      end
      if (addr == '0) begin
        sel = '0;
        pw  = 1'b0;
      end
      fwd_data_o[p*XLEN +: XLEN] = sel;
      port_wait[p]               = pw;
    end
  end

  assign stall   = iss_valid_i & ~flush_i & (|port_wait);
  assign capture = iss_valid_i & iss_wen_i & (iss_rd_i != '0) & ~stall & ~flush_i;

  always_comb begin : next_state
    for (int k = 0; k < DEPTH; k++) begin
      v_d[k]    = 1'b0;
      rd_d[k]   = '0;
      ld_d[k]   = 1'b0;
      dv_d[k]   = 1'b0;
      data_d[k] = '0;
    end
    // Bubbles are all-zero so retirement outputs read as zero when idle.
    v_d[0]  = capture;
    rd_d[0] = capture ? iss_rd_i : '0;
    ld_d[0] = capture & iss_load_i;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      rd_d[k]   = rd_q[k-1];
      ld_d[k]   = ld_q[k-1];
      dv_d[k]   = dv_q[k-1];
      data_d[k] = data_q[k-1];
      if (v_q[k-1] && (k - 1 == 0) && !ld_q[k-1]) begin
        dv_d[k]   = 1'b1;
        data_d[k] = exe_data_i;
      end
      if (v_q[k-1] && (k - 1 == LD_STAGE - 1) && ld_q[k-1]) begin
        dv_d[k]   = 1'b1;
        data_d[k] = ld_data_i;
      end
    end
    if (flush_i) begin
      v_d[1]    = 1'b0;
      rd_d[1]   = '0;
      ld_d[1]   = 1'b0;
      dv_d[1]   = 1'b0;
      data_d[1] = '0;
    end
  end

  assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        rd_q[k]   <= '0;
        ld_q[k]   <= 1'b0;
        dv_q[k]   <= 1'b0;
        data_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= v_d[k];
        rd_q[k]   <= rd_d[k];
        ld_q[k]   <= ld_d[k];
        dv_q[k]   <= dv_d[k];
        data_q[k] <= data_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign wb_valid_o  = v_q[DEPTH-1];
  assign wb_rd_o     = rd_q[DEPTH-1];
  assign wb_data_o   = sval[DEPTH-1];
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_rv_fwd_unit.sv
module tb_rv_fwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_wen, iss_load, flush;
  logic [4:0]  iss_rd;
  logic [31:0] exe_data, ld_data;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [63:0] fwd_data;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] stall_cnt;

  // Second instance (DEPTH=8, LD_STAGE=8) stalls 7 of every 8 cycles,
  // which lets the stall counter saturate in a reasonable cycle count.
  logic        s_valid, s_wen, s_load, s_flush;
  logic [4:0]  s_rd, s_rs;
  logic [31:0] s_exe, s_ld, s_rf, s_fwd, s_wb_data;
  logic        s_stall, s_wb_valid;
  logic [4:0]  s_wb_rd;
  logic [15:0] s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_fwd_unit dut (
    .clk_i(clk), .rst_i(rst),
    .iss_valid_i(iss_valid), .iss_wen_i(iss_wen), .iss_load_i(iss_load),
    .iss_rd_i(iss_rd), .flush_i(flush),
    .exe_data_i(exe_data), .ld_data_i(ld_data),
    .rs_addr_i(rs_addr), .rf_data_i(rf_data),
    .fwd_data_o(fwd_data), .stall_o(stall),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .stall_cnt_o(stall_cnt)
  );

  rv_fwd_unit #(.DEPTH(8), .LD_STAGE(8), .NRD(1)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .iss_valid_i(s_valid), .iss_wen_i(s_wen), .iss_load_i(s_load),
    .iss_rd_i(s_rd), .flush_i(s_flush),
    .exe_data_i(s_exe), .ld_data_i(s_ld),
    .rs_addr_i(s_rs), .rf_data_i(s_rf),
    .fwd_data_o(s_fwd), .stall_o(s_stall),
    .wb_valid_o(s_wb_valid), .wb_rd_o(s_wb_rd), .wb_data_o(s_wb_data),
    .stall_cnt_o(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wen = 1'b0; iss_load = 1'b0; iss_rd = '0;
    flush = 1'b0; exe_data = '0; ld_data = '0; rs_addr = '0; rf_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd4;
    rs_addr = {5'd0, 5'd3};
    rf_data = {32'h44, 32'h33};
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (fwd_data[31:0] !== 32'h33) begin n_err++; $display("FAIL rst_fwd0: got %h want 00000033", fwd_data[31:0]); end
    n_cmp++; if (fwd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL rst_fwd1_x0: got %h want 00000000", fwd_data[63:32]); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
    tick();
    rst = 1'b0;
    idle();
    rs_addr = {5'd0, 5'd4};
    rf_data = {32'h0, 32'h4444};
    @(negedge clk);
    n_cmp++; if (fwd_data[31:0] !== 32'h4444) begin n_err++; $display("FAIL rst_dropped_write: got %h want 00004444", fwd_data[31:0]); end
    tick();
  endtask

  task automatic test_alu_b2b();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    iss_valid = 1'b1;
    rs_addr = {5'd0, 5'd5};
    exe_data = 32'h11;
    rf_data = {32'h0, 32'hDEAD};
    @(negedge clk);
    n_cmp++; if (fwd_data[31:0] !== 32'h11) begin n_err++; $display("FAIL alu_fwd0: got %h want 00000011", fwd_data[31:0]); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_load_use();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_load = 1'b1; iss_rd = 5'd6;
    tick();
    idle();
    iss_valid = 1'b1;
    rs_addr = {5'd6, 5'd0};
    rf_data = {32'h99, 32'h0};
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_first: got %b want 1", stall); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt); end
    tick();
    ld_data = 32'hAB;
    @(negedge clk);
    n_cmp++; if (fwd_data[63:32] !== 32'hAB) begin n_err++; $display("FAIL lu_fwd1: got %h want 000000ab", fwd_data[63:32]); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_second: got %b want 0", stall); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
    tick();
    idle();
    rs_addr = {5'd6, 5'd0};
    rf_data = {32'h99, 32'h0};
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL lu_wb_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd6) begin n_err++; $display("FAIL lu_wb_rd: got %0d want 6", wb_rd); end
    n_cmp++; if (wb_data !== 32'hAB) begin n_err++; $display("FAIL lu_wb_data: got %h want 000000ab", wb_data); end
    n_cmp++; if (fwd_data[63:32] !== 32'hAB) begin n_err++; $display("FAIL lu_fwd_at_wb: got %h want 000000ab", fwd_data[63:32]); end
    tick();
    repeat (2) tick();
  endtask

  task automatic test_youngest();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd7;
    tick();
    exe_data = 32'h1;
    tick();
    idle();
    exe_data = 32'h2;
    tick();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_load = 1'b1; iss_rd = 5'd7;
    rs_addr = {5'd0, 5'd7};
    rf_data = {32'h77, 32'hBAD};
    @(negedge clk);
    n_cmp++; if (fwd_data[31:0] !== 32'h2) begin n_err++; $display("FAIL yw_fwd0: got %h want 00000002", fwd_data[31:0]); end
    n_cmp++; if (fwd_data[63:32] !== 32'h0) begin n_err++; $display("FAIL yw_x0: got %h want 00000000", fwd_data[63:32]); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL yw_stall: got %b want 0", stall); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h1) begin
      n_err++; $display("FAIL yw_wb_old: got v=%b rd=%0d data=%h want v=1 rd=7 data=00000001", wb_valid, wb_rd, wb_data);
    end
    tick();
    idle();
    iss_valid = 1'b1;
    rs_addr = {5'd0, 5'd7};
    rf_data = {32'h0, 32'hBAD};
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL yw_young_not_ready: got %b want 1", stall); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL yw_cnt: got %0d want 1", stall_cnt); end
    tick();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_flush();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd8; flush = 1'b1;
    exe_data = 32'h88;
    tick();
    idle();
    iss_valid = 1'b1;
    rs_addr = {5'd0, 5'd8};
    rf_data = {32'h0, 32'h1234};
    @(negedge clk);
    n_cmp++; if (fwd_data[31:0] !== 32'h1234) begin n_err++; $display("FAIL fl_x8_rf: got %h want 00001234", fwd_data[31:0]); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL fl_cnt: got %0d want 2", stall_cnt); end
    tick();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    flush = 1'b1;
    exe_data = 32'h99;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      rs_addr = {5'd0, 5'd9};
      rf_data = {32'h0, 32'h5678};
      @(negedge clk);
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fl_x9_wb_%0d: got %b want 0", i, wb_valid); end
      n_cmp++; if (fwd_data[31:0] !== 32'h5678) begin n_err++; $display("FAIL fl_x9_rf_%0d: got %h want 00005678", i, fwd_data[31:0]); end
      tick();
    end
  endtask

  task automatic test_retire();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd10;
    tick();
    idle();
    exe_data = 32'h55;
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rt_early: got %b want 0", wb_valid); end
    tick();
    idle();
    rs_addr = {5'd0, 5'd10};
    rf_data = '0;
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL rt_wb_valid: got %b want 1", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd10) begin n_err++; $display("FAIL rt_wb_rd: got %0d want 10", wb_rd); end
    n_cmp++; if (wb_data !== 32'h55) begin n_err++; $display("FAIL rt_wb_data: got %h want 00000055", wb_data); end
    n_cmp++; if (fwd_data[31:0] !== 32'h55) begin n_err++; $display("FAIL rt_same_cycle_read: got %h want 00000055", fwd_data[31:0]); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_midflight();
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd11;
    tick();
    iss_rd = 5'd12; exe_data = 32'h11;
    tick();
    iss_rd = 5'd13; iss_load = 1'b1; exe_data = 32'h12;
    tick();
    rst = 1'b1;
    iss_rd = 5'd14; iss_load = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    iss_valid = 1'b1;
    rs_addr = {5'd12, 5'd13};
    rf_data = {32'hBEEF, 32'hCAFE};
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_stall: got %b want 0", stall); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rm_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (fwd_data !== {32'hBEEF, 32'hCAFE}) begin n_err++; $display("FAIL rm_fwd: got %h want 0000beef0000cafe", fwd_data); end
    n_cmp++; if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin n_err++; $display("FAIL rm_wb_fields: got rd=%0d data=%h want rd=0 data=0", wb_rd, wb_data); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rm_wb_valid_%0d: got %b want 0", i, wb_valid); end
      tick();
      idle();
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    s_valid = 1'b1; s_wen = 1'b1; s_load = 1'b1; s_rd = 5'd6; s_rs = 5'd6;
    s_flush = 1'b0; s_exe = '0; s_ld = 32'h1; s_rf = '0;
    tick();
    @(negedge clk);
    n_cmp++; if (s_stall !== 1'b1) begin n_err++; $display("FAIL sat_first_stall: got %b want 1", s_stall); end
    repeat (799) tick();
    n_cmp++; if (s_cnt !== 16'd700) begin n_err++; $display("FAIL sat_cnt_800: got %0d want 700", s_cnt); end
    repeat (74896 - 800) tick();
    n_cmp++; if (s_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_cnt_fffe: got %h want fffe", s_cnt); end
    repeat (2) tick();
    n_cmp++; if (s_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt_ffff: got %h want ffff", s_cnt); end
    repeat (102) tick();
    n_cmp++; if (s_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt_hold: got %h want ffff", s_cnt); end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    s_valid = 1'b0; s_wen = 1'b0; s_load = 1'b0; s_rd = '0; s_rs = '0;
    s_flush = 1'b0; s_exe = '0; s_ld = '0; s_rf = '0;
    test_reset();
    test_alu_b2b();
    test_load_use();
    test_youngest();
    test_flush();
    test_retire();
    test_reset_midflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
